// File: rtl/result_collect_buffer.sv
// Gathers the NxN bottom-edge systolic results per lane, then drains them row-major over valid/ready.
// Drain starts the cycle after the last lane write; out_ready_i low holds data. Optional ReLU on drain: RESULT_RELU_EN.
module result_collect_buffer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [0:N-1][DATA_WIDTH-1:0]     lane_data_i,
  input  logic [N-1:0]                     lane_valid_i,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             out_last_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);

  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(N * N);
  localparam logic [CW-1:0] CNT_FULL  = CW'(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt [N];
  logic [AW-1:0]         r_rd_addr;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [N*N];

  logic [N-1:0]          w_full;
  logic [N-1:0]          w_wr;
  logic [AW-1:0]         w_waddr [N];
  logic                  w_all_full;
  logic                  w_hs;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_rd_word;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_full[j]  = (r_cnt[j] == CNT_FULL);
      w_wr[j]    = (r_state == S_COLLECT) && lane_valid_i[j] && !w_full[j];
      w_waddr[j] = AW'(r_cnt[j]) * AW'(N) + AW'(j);
    end
  end

  assign w_all_full = &w_full;
  assign w_last     = (r_rd_addr == LAST_ADDR);
  assign w_hs       = out_valid_o && out_ready_i;
  assign w_rd_word  = r_mem[r_rd_addr];

  // Buffer is deliberately unreset; only locations written in a complete run are ever drained.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N; j++) begin
      if (w_wr[j]) r_mem[w_waddr[j]] <= lane_data_i[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_overflow <= 1'b0;
      for (int j = 0; j < N; j++) r_cnt[j] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state    <= S_COLLECT;
            r_rd_addr  <= '0;
            r_overflow <= 1'b0;
            for (int j = 0; j < N; j++) r_cnt[j] <= '0;
          end
        end
        S_COLLECT: begin
          for (int j = 0; j < N; j++) begin
            if (w_wr[j]) r_cnt[j] <= r_cnt[j] + CW'(1);
            else if (lane_valid_i[j] && w_full[j]) r_overflow <= 1'b1;
          end
          // Registered counts: the move happens the cycle after the final write.
          if (w_all_full) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (w_last) begin
              r_state   <= S_DONE;
              r_rd_addr <= '0;
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o = (r_state == S_DRAIN);
  assign out_last_o  = out_valid_o && w_last;
  assign busy_o      = (r_state == S_COLLECT) || (r_state == S_DRAIN);
  assign done_o      = (r_state == S_DONE);
  assign overflow_o  = r_overflow;

`ifdef RESULT_RELU_EN
  assign out_data_o = w_rd_word[DATA_WIDTH-1] ? '0 : w_rd_word;
`else
  assign out_data_o = w_rd_word;
`endif

endmodule

// File: tb/tb_result_collect_buffer.sv
// Directed bench for result_collect_buffer at N=4: aligned, staggered, throttled, overflow, reset-abort, ReLU.
module tb_result_collect_buffer;

  localparam int N  = 4;
  localparam int DW = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   start_i = 1'b0;
  logic [0:N-1][DW-1:0]   lane_data_i = '0;
  logic [N-1:0]           lane_valid_i = '0;
  logic [DW-1:0]          out_data_o;
  logic                   out_valid_o;
  logic                   out_ready_i = 1'b0;
  logic                   out_last_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   overflow_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [N*N];

  result_collect_buffer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .lane_data_i(lane_data_i), .lane_valid_i(lane_valid_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] drained(input logic [DW-1:0] w);
`ifdef RESULT_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Lane j delivers row r at cycle d[j]+r; optional extra (overflowing) beat on lane xl at cycle xc.
  task automatic collect(input logic [DW-1:0] base, input int d0, input int d1, input int d2,
                         input int d3, input int xl, input int xc, input bit neg11);
    int d [N];
    int last_c;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_ovf_clr", overflow_o, 0);
    last_c = 0;
    for (int j = 0; j < N; j++) if (d[j] + N - 1 > last_c) last_c = d[j] + N - 1;
    if (xl >= 0 && xc > last_c) last_c = xc;
    for (int c = 0; c <= last_c; c++) begin
      for (int j = 0; j < N; j++) begin
        int r;
        r = c - d[j];
        lane_valid_i[j] = 1'b0;
        if (r >= 0 && r < N) begin
          lane_valid_i[j] = 1'b1;
          lane_data_i[j]  = (neg11 && j == 1 && r == 1) ? 32'hFFFF_FFF0 : base + DW'(16 * r + j);
          model[r*N+j]    = lane_data_i[j];
        end
        if (j == xl && c == xc) begin
          lane_valid_i[j] = 1'b1;
          lane_data_i[j]  = 32'h0000_DEAD;
        end
      end
      @(negedge clk_i);
    end
    lane_valid_i = '0;
    check("vld_after_final_write", out_valid_o, 0);
    @(negedge clk_i);
    check("vld_next_cycle", out_valid_o, 1);
  endtask

  task automatic drain(input bit toggle, input int max_hs, output int cycles);
    int idx;
    bit held_v;
    logic [DW-1:0] held_d;
    idx = 0; cycles = 0; held_v = 1'b0; held_d = '0;
    while (idx < max_hs && cycles < 200) begin
      out_ready_i = toggle ? cycles[0] : 1'b1;
      if (out_valid_o) begin
        if (held_v) check("hold_data", out_data_o, held_d);
        if (out_ready_i) begin
          check($sformatf("data[%0d]", idx), out_data_o, drained(model[idx]));
          check($sformatf("last[%0d]", idx), out_last_o, (idx == N*N-1));
          idx++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = out_data_o;
        end
      end
      cycles++;
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;
    check("drain_handshakes", idx, max_hs);
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_valid", out_valid_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ovf", overflow_o, 0);

    // Aligned arrival, sustained drain.
    collect(32'h0, 0, 0, 0, 0, -1, 0, 1'b0);
    drain(1'b0, N*N, cyc);
    check("aligned_cycles", cyc, 16);
    check("aligned_done", done_o, 1);
    check("aligned_vld_off", out_valid_o, 0);
    check("aligned_not_busy", busy_o, 0);

    // Systolic stagger, sustained drain.
    collect(32'h100, 0, 1, 2, 3, -1, 0, 1'b0);
    drain(1'b0, N*N, cyc);
    check("skew_cycles", cyc, 16);
    check("skew_done", done_o, 1);

    // Ready toggling 0,1,0,1...
    collect(32'h200, 0, 0, 0, 0, -1, 0, 1'b0);
    drain(1'b1, N*N, cyc);
    check("toggle_cycles", cyc, 32);
    check("toggle_done", done_o, 1);

    // Lane 2 gets a fifth beat while lane 3 is still filling.
    collect(32'h300, 0, 0, 0, 2, 2, 4, 1'b0);
    check("ovf_set", overflow_o, 1);
    drain(1'b0, N*N, cyc);
    check("ovf_sticky", overflow_o, 1);

    // Abort mid-drain with reset; start also clears overflow.
    collect(32'h400, 0, 0, 0, 0, -1, 0, 1'b0);
    drain(1'b0, 5, cyc);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_valid", out_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);

    // Fresh run from address 0 with a negative element at (1,1).
    collect(32'h500, 0, 1, 2, 3, -1, 0, 1'b1);
    drain(1'b0, N*N, cyc);
    check("fresh_cycles", cyc, 16);
    check("fresh_done", done_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
